button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 136 +++++++++++++
 tb/tb_button_conditioner.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, press/release debounce FSM,
// registered level plus single-cycle press/release/long-press pulses and a press counter.
module button_conditioner #(
    parameter logic [19:0] DEBOUNCE_CYCLES   = 20'd1000000,
    parameter logic [27:0] LONG_PRESS_CYCLES = 28'd100000000,
    parameter logic        ACTIVE_LOW_IN     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       btn_long,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    localparam logic [19:0] LAST_DEB  = DEBOUNCE_CYCLES - 20'd1;
    localparam logic [27:0] LAST_HOLD = LONG_PRESS_CYCLES - 28'd1;

    logic        sync_meta;
    logic        sync;

    state_t      state, state_nxt;
    logic [19:0] deb_cnt, deb_nxt;
    logic [27:0] hold_cnt, hold_nxt;
    logic        long_fired, fired_nxt;
    logic        level_nxt, press_nxt, release_nxt, long_nxt;
    logic [7:0]  count_nxt;

    // Polarity is normalised before the first flop so the idle value is always 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= btn_in ^ ACTIVE_LOW_IN;
            sync      <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            long_fired  <= 1'b0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nxt;
            deb_cnt     <= deb_nxt;
            hold_cnt    <= hold_nxt;
            long_fired  <= fired_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            btn_long    <= long_nxt;
            press_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        deb_nxt     = deb_cnt;
        hold_nxt    = hold_cnt;
        fired_nxt   = long_fired;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        count_nxt   = press_count;

        unique case (state)
            IDLE: begin
                if (sync) begin
                    state_nxt = DEB_PRESS;
                    deb_nxt   = '0;
                end
            end
            DEB_PRESS: begin
                if (!sync) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt == LAST_DEB) begin
                    state_nxt = PRESSED;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                    count_nxt = press_count + 8'd1;
                    hold_nxt  = '0;
                    fired_nxt = 1'b0;
                end else begin
                    deb_nxt = deb_cnt + 20'd1;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_nxt = DEB_RELEASE;
                    deb_nxt   = '0;
                end else begin
                    if (hold_cnt != LAST_HOLD) begin
                        hold_nxt = hold_cnt + 28'd1;
                    end
                    if (hold_cnt == LAST_HOLD && !long_fired) begin
                        long_nxt  = 1'b1;
                        fired_nxt = 1'b1;
                    end
                end
            end
            DEB_RELEASE: begin
                // Returning to PRESSED keeps hold_cnt/long_fired: a release bounce is not a new press.
                if (sync) begin
                    state_nxt = PRESSED;
                end else if (deb_cnt == LAST_DEB) begin
                    state_nxt   = IDLE;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + 20'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a run-length reference model predicts pulses per clock edge,
// a negedge monitor pops and compares them for an active-high and an active-low instance.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn   = 1'b0;
    logic       btn_pin_n;

    logic       lvl0, prs0, rel0, lng0;
    logic [7:0] cnt0;
    logic       lvl1, prs1, rel1, lng1;
    logic [7:0] cnt1;

    assign btn_pin_n = ~btn;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES  (20'd4),
        .LONG_PRESS_CYCLES(28'd10),
        .ACTIVE_LOW_IN    (1'b0)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn),
        .btn_level  (lvl0),
        .btn_press  (prs0),
        .btn_release(rel0),
        .btn_long   (lng0),
        .press_count(cnt0)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES  (20'd4),
        .LONG_PRESS_CYCLES(28'd10),
        .ACTIVE_LOW_IN    (1'b1)
    ) u_dut_n (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_pin_n),
        .btn_level  (lvl1),
        .btn_press  (prs1),
        .btn_release(rel1),
        .btn_long   (lng1),
        .press_count(cnt1)
    );

    // kind: 1 press, 2 release, 3 long
    typedef struct packed {
        logic [1:0]  kind;
        int unsigned cyc;
        logic [7:0]  cnt;
    } ev_t;

    ev_t         q0[$];
    ev_t         q1[$];
    int          tests = 0;
    int          fails = 0;

    logic        pipe[$];
    logic        m_level;
    int          run;
    int          hold;
    bit          fired;
    logic [7:0]  m_count;
    int unsigned cyc = 0;

    task automatic model_reset();
        pipe    = '{1'b0, 1'b0};
        m_level = 1'b0;
        run     = 0;
        hold    = 0;
        fired   = 1'b0;
        m_count = 8'd0;
    endtask

    task automatic push_ev(input logic [1:0] kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.cnt  = m_count;
        q0.push_back(e);
        q1.push_back(e);
    endtask

    // Level flips once D+1 consecutive synchronised samples disagree with it;
    // held time only accrues on agreeing samples outside a release-bounce run.
    task automatic model_loop();
        logic samp;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                samp = pipe.pop_front();
                pipe.push_back(btn);
                if (m_level) begin
                    if (samp) begin
                        if (run == 0) begin
                            if (hold == L - 1) begin
                                if (!fired) begin
                                    fired = 1'b1;
                                    push_ev(2'd3);
                                end
                            end else begin
                                hold++;
                            end
                        end
                        run = 0;
                    end else begin
                        run++;
                        if (run == D + 1) begin
                            m_level = 1'b0;
                            run     = 0;
                            push_ev(2'd2);
                        end
                    end
                end else begin
                    if (samp) begin
                        run++;
                        if (run == D + 1) begin
                            m_level = 1'b1;
                            run     = 0;
                            hold    = 0;
                            fired   = 1'b0;
                            m_count = m_count + 8'd1;
                            push_ev(2'd1);
                        end
                    end else begin
                        run = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int id, input logic lvl, input logic prs,
                             input logic rel, input logic lng, input logic [7:0] cnt);
        int         n;
        logic [1:0] kind;
        ev_t        e;
        bit         empty;
        n    = int'(prs) + int'(rel) + int'(lng);
        kind = prs ? 2'd1 : (rel ? 2'd2 : (lng ? 2'd3 : 2'd0));
        tests++;
        if (n > 1) begin
            fails++;
            $display("FAIL pulse_overlap dut%0d cyc %0d: press=%0b release=%0b long=%0b, required at most one",
                     id, cyc, prs, rel, lng);
        end
        if (kind != 2'd0) begin
            empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
            tests++;
            if (empty) begin
                fails++;
                $display("FAIL unexpected_pulse dut%0d cyc %0d: kind %0d, required none", id, cyc, kind);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                if (e.kind != kind || e.cyc != cyc || (kind == 2'd1 && e.cnt != cnt)) begin
                    fails++;
                    $display("FAIL pulse dut%0d: got kind %0d cyc %0d count %0d, required kind %0d cyc %0d count %0d",
                             id, kind, cyc, cnt, e.kind, e.cyc, e.cnt);
                end
            end
        end
        tests++;
        if (lvl !== m_level || cnt !== m_count) begin
            fails++;
            $display("FAIL level_count dut%0d cyc %0d: got level %0b count %0d, required level %0b count %0d",
                     id, cyc, lvl, cnt, m_level, m_count);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            check_dut(0, lvl0, prs0, rel0, lng0, cnt0);
            check_dut(1, lvl1, prs1, rel1, lng1, cnt1);
        end
    endtask

    task automatic seg(input logic v, input int n);
        btn = v;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse(input int n);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({lvl0, prs0, rel0, lng0, cnt0} !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs dut0: got %b, required 0", {lvl0, prs0, rel0, lng0, cnt0});
        end
        tests++;
        if ({lvl1, prs1, rel1, lng1, cnt1} !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs dut1: got %b, required 0", {lvl1, prs1, rel1, lng1, cnt1});
        end
        repeat (n) begin
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        fork
            model_loop();
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        seg(1'b0, 3);

        // Reset asserted while the button is held, then re-debounced
        seg(1'b1, 9);
        reset_pulse(3);
        seg(1'b1, 12);
        seg(1'b0, 12);

        // Clean long hold
        seg(1'b1, 20);
        seg(1'b0, 12);

        // Press bounce
        seg(1'b1, 2); seg(1'b0, 2); seg(1'b1, 2); seg(1'b0, 2);
        seg(1'b1, 15);
        seg(1'b0, 12);

        // Release bounce while pressed
        seg(1'b1, 8); seg(1'b0, 2); seg(1'b1, 15);
        seg(1'b0, 12);

        // Too-short press
        seg(1'b1, 3);
        seg(1'b0, 10);

        // 256 clean presses from a fresh reset wrap the counter back to zero
        reset_pulse(2);
        seg(1'b0, 4);
        for (int i = 0; i < 256; i++) begin
            seg(1'b1, $urandom_range(7, 14));
            seg(1'b0, $urandom_range(7, 12));
        end
        seg(1'b0, 4);
        tests++;
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            fails++;
            $display("FAIL count_wrap: got %0d/%0d, required 0/0", cnt0, cnt1);
        end

        // Random bouncy activity
        for (int i = 0; i < 300; i++) begin
            seg(1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        seg(1'b0, 15);

        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
